rr_arbiter_fsm: RTL and testbench

- Round-robin arbiter that shares one resource among N requesters.
- A small Moore-style state machine grants the resource to one requester at a time.
- The owner keeps the grant while its request stays high, up to MAX_HOLD cycles. After that it must yield if anyone else is waiting.
- Sits between requester FSMs and the single shared unit they drive, and produces the one-hot select for that unit.

---
 rtl/rr_arbiter_fsm.sv | 149 ++++++++++++++
 tb/tb_rr_arbiter_fsm.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter: one owner at a time, grant held while requested, forced
// yield after MAX_HOLD cycles when another requester is waiting.
module rr_arbiter_fsm #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           yield
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int unsigned NU = N;
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    YIELD
  } state_t;

  state_t         state, nxt_state;
  logic [N-1:0]   nxt_gnt;
  logic [IDW-1:0] nxt_id;
  logic           nxt_busy, nxt_yield;
  logic [IDW-1:0] ptr, nxt_ptr;
  logic [HW-1:0]  hold_cnt, nxt_hold;

  logic [IDW-1:0] owner_inc;
  logic [IDW-1:0] pick_idle, pick_hand;
  logic           others_waiting;

  // First set bit of m scanning p, p+1, ... wrapping at N (N need not be 2^k).
  function automatic logic [IDW-1:0] pick(input logic [N-1:0] m, input logic [IDW-1:0] p);
    logic [IDW-1:0] r;
    logic [IDW-1:0] i2;
    logic           found;
    int unsigned    idx;
    r     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = (32'(p) + k) % NU;
      i2  = IDW'(idx);
      if (!found && m[i2]) begin
        r     = i2;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign owner_inc      = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
  assign pick_idle      = pick(req, ptr);
  assign pick_hand      = pick(req, owner_inc);
  assign others_waiting = |(req & ~gnt);

  always_comb begin
    nxt_state = state;
    nxt_gnt   = gnt;
    nxt_id    = gnt_id;
    nxt_busy  = busy;
    nxt_yield = 1'b0;
    nxt_ptr   = ptr;
    nxt_hold  = hold_cnt;
    unique case (state)
      IDLE, YIELD: begin
        if (|req) begin
          nxt_state = BUSY;
          nxt_gnt   = onehot(pick_idle);
          nxt_id    = pick_idle;
          nxt_busy  = 1'b1;
          nxt_hold  = HW'(1);
        end else begin
          nxt_state = IDLE;
          nxt_gnt   = '0;
          nxt_busy  = 1'b0;
          nxt_hold  = '0;
        end
      end
      BUSY: begin
        // Release takes precedence over expiry, so a simultaneous drop hands off directly.
        if (!req[gnt_id]) begin
          nxt_ptr = owner_inc;
          if (|req) begin
            nxt_gnt  = onehot(pick_hand);
            nxt_id   = pick_hand;
            nxt_hold = HW'(1);
          end else begin
            nxt_state = IDLE;
            nxt_gnt   = '0;
            nxt_busy  = 1'b0;
            nxt_hold  = '0;
          end
        end else if (hold_cnt == HOLD_MAX) begin
          if (others_waiting) begin
            nxt_state = YIELD;
            nxt_gnt   = '0;
            nxt_busy  = 1'b0;
            nxt_yield = 1'b1;
            nxt_ptr   = owner_inc;
            nxt_hold  = '0;
          end
        end else begin
          nxt_hold = hold_cnt + 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_gnt   = '0;
        nxt_busy  = 1'b0;
        nxt_hold  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      yield    <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= nxt_state;
      gnt      <= nxt_gnt;
      gnt_id   <= nxt_id;
      busy     <= nxt_busy;
      yield    <= nxt_yield;
      ptr      <= nxt_ptr;
      hold_cnt <= nxt_hold;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Scoreboard bench for rr_arbiter_fsm: a per-cycle reference model queues the
// expected registered outputs; a negedge monitor pops and compares.
module tb_rr_arbiter_fsm;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] req  = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         yield;

  rr_arbiter_fsm #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rstn(rstn), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .yield(yield)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    int           id;
    bit           busy;
    bit           yld;
    int           hold;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: owner index (-1 = none), priority pointer, hold count.
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_hold  = 0;
  bit           m_y;
  logic [N-1:0] m_r;
  exp_t         m_e;
  exp_t         mon_e;

  function automatic int ref_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rstn) begin
      m_r = req;
      m_y = 1'b0;
      if (m_owner < 0) begin
        if (m_r != 0) begin
          m_owner = ref_pick(m_r, m_ptr);
          m_hold  = 1;
        end else begin
          m_hold = 0;
        end
      end else if (!m_r[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        if (m_r != 0) begin
          m_owner = ref_pick(m_r, m_ptr);
          m_hold  = 1;
        end else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end else if (m_hold == MH && (m_r & ~(N'(1) << m_owner)) != 0) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_hold  = 0;
        m_y     = 1'b1;
      end else if (m_hold < MH) begin
        m_hold++;
      end
      m_e.gnt  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      m_e.id   = m_owner;
      m_e.busy = (m_owner >= 0);
      m_e.yld  = m_y;
      m_e.hold = m_hold;
      sbq.push_back(m_e);
    end
  end

  always @(negedge rstn) begin
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    sbq.delete();
  end

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_yield", int'(yield), 0);
      chk("rst_gnt_id", int'(gnt_id), 0);
    end else if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("gnt", int'(gnt), int'(mon_e.gnt));
      chk("busy", int'(busy), int'(mon_e.busy));
      chk("yield", int'(yield), int'(mon_e.yld));
      if (mon_e.busy) begin
        chk("gnt_id", int'(gnt_id), mon_e.id);
        chk("hold_cnt", int'(dut.hold_cnt), mon_e.hold);
      end
    end
    compared++;
    assert ($onehot0(gnt)) else begin
      mismatched++;
      $display("FAIL inv_onehot: gnt=%b not zero/one-hot", gnt);
    end
    compared++;
    assert (busy == |gnt) else begin
      mismatched++;
      $display("FAIL inv_busy: busy=%0d gnt=%b", busy, gnt);
    end
    compared++;
    assert (!busy || gnt[gnt_id]) else begin
      mismatched++;
      $display("FAIL inv_gnt_id: gnt_id=%0d gnt=%b", gnt_id, gnt);
    end
    compared++;
    assert (int'(dut.hold_cnt) <= MH) else begin
      mismatched++;
      $display("FAIL inv_hold: hold_cnt=%0d exceeds %0d", dut.hold_cnt, MH);
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rstn = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    step(1);
  endtask

  int           cnt[N];
  logic [N-1:0] reraise;
  int           order[$];
  int           last_id;
  int           gaps;
  int           bad;

  initial begin
    // 1: reset and single request
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    step(1);
    req = 4'b0100;
    step(1);
    chk("t1_gnt", int'(gnt), 4'b0100);
    chk("t1_id", int'(gnt_id), 2);
    step(4);
    chk("t1_gnt_last", int'(gnt), 4'b0100);
    req = '0;
    step(1);
    chk("t1_release", int'(gnt), 0);
    req = 4'b1001;
    step(1);
    chk("t1_ptr3", int'(gnt), 4'b1000);
    req = '0;
    step(2);

    // 2: full contention, each owner releases after 2 grant cycles
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    reraise = '0;
    last_id = -1;
    gaps    = 0;
    order.delete();
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      step(1);
      if (busy && int'(gnt_id) != last_id) begin
        order.push_back(int'(gnt_id));
        last_id = int'(gnt_id);
      end
      if (!busy && last_id >= 0 && order.size() < 5) gaps++;
      req     = req | reraise;
      reraise = '0;
      if (m_owner >= 0) begin
        cnt[m_owner]++;
        if (cnt[m_owner] == 2) begin
          cnt[m_owner]      = 0;
          req[m_owner]      = 1'b0;
          reraise[m_owner]  = 1'b1;
        end
      end
    end
    chk("t2_order_len", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) chk("t2_order", order[k], k % N);
    chk("t2_gaps", gaps, 0);
    req = '0;
    step(2);

    // 3: forced yield
    do_reset();
    req = 4'b0010;
    step(3);
    req = 4'b1010;
    step(5);
    chk("t3_gnt8", int'(gnt), 4'b0010);
    step(1);
    chk("t3_yield_gnt", int'(gnt), 0);
    chk("t3_yield", int'(yield), 1);
    step(1);
    chk("t3_next", int'(gnt), 4'b1000);
    chk("t3_yield_drop", int'(yield), 0);
    step(20);
    req = '0;
    step(2);

    // 4: uncontended hold saturates
    do_reset();
    req = 4'b0001;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (gnt != 4'b0001 || yield) bad++;
    end
    chk("t4_hold_grant", bad, 0);
    chk("t4_hold_sat", int'(dut.hold_cnt), MH);
    req = '0;
    step(2);

    // 5: release on the expiry cycle
    do_reset();
    req = 4'b0100;
    step(3);
    req = 4'b0101;
    for (int c = 0; c < 20 && m_hold != MH; c++) step(1);
    chk("t5_pre", int'(gnt), 4'b0100);
    req = 4'b0001;
    step(1);
    chk("t5_gnt", int'(gnt), 4'b0001);
    chk("t5_no_yield", int'(yield), 0);
    req = '0;
    step(2);

    // 6: asynchronous reset mid-grant
    do_reset();
    req = 4'b1000;
    step(3);
    chk("t6_pre", int'(gnt), 4'b1000);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_gnt", int'(gnt), 0);
    chk("t6_async_busy", int'(busy), 0);
    req = 4'b1001;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    step(1);
    chk("t6_first", int'(gnt), 4'b0001);
    req = '0;
    step(2);

    // Random traffic with occasional resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 149) == 0) do_reset();
      else step(1);
    end
    req = '0;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
